// File: rtl/pose_pkg.sv
// Shared types and default Q-format widths for the pose controller slice.
//   pose_cmd_t   : motion command encoding carried on cmd_in
//   pose_state_t : controller FSM states
//   is_rotate()  : true for the two rotation commands
package pose_pkg;

  localparam int POSE_WIDTH = 16;
  localparam int POSE_FRAC  = 8;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BWD   = 3'd2,
    CMD_STR_L = 3'd3,
    CMD_STR_R = 3'd4,
    CMD_ROT_L = 3'd5,
    CMD_ROT_R = 3'd6
  } pose_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_CHECK,
    ST_COMMIT,
    ST_REJECT
  } pose_state_t;

  function automatic logic is_rotate(input pose_cmd_t c);
    return (c == CMD_ROT_L) || (c == CMD_ROT_R);
  endfunction

endpackage

// File: rtl/fxp_mul_shift.sv
// Signed fixed-point multiply: p_out = (a_in * b_in) >>> FRAC, truncated
// toward -inf and kept to WIDTH bits. Purely combinational.
//   a_in, b_in : signed Q operands (WIDTH bits)
//   p_out      : signed Q product (WIDTH bits)
module fxp_mul_shift
  import pose_pkg::*;
#(
  parameter int WIDTH = POSE_WIDTH,
  parameter int FRAC  = POSE_FRAC
) (
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] p_out
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] full;
  logic                      unused_bits;

  // Sign-extend first so the full double-width product is exact.
  assign a_ext = {{WIDTH{a_in[WIDTH-1]}}, a_in};
  assign b_ext = {{WIDTH{b_in[WIDTH-1]}}, b_in};
  assign full  = a_ext * b_ext;

  // Taking bits [FRAC +: WIDTH] is the arithmetic shift plus truncation.
  assign p_out       = full[FRAC +: WIDTH];
  assign unused_bits = ^{full[2*WIDTH-1:WIDTH+FRAC], full[FRAC-1:0]};

endmodule

// File: rtl/pose_controller.sv
// Player pose controller: accepts one motion command at a time, computes the
// candidate pose in signed fixed point, checks translations against the maze
// map and commits the new pose (optionally only on a frame boundary).
//   clk_in, rst_in_n               : clock, async active-low reset
//   cmd_valid_in/cmd_in/cmd_ready_out : command handshake (ready only in IDLE)
//   frame_sync_in                  : frame-start pulse gating the commit
//   map_req_out/map_addr_out/map_data_in : map cell read port, MAP_LAT latency
//   posX..planeY                   : committed pose
//   pose_update_out/collision_out  : one-cycle result pulses
module pose_controller
  import pose_pkg::*;
#(
  parameter int                      WIDTH        = POSE_WIDTH,
  parameter int                      FRAC         = POSE_FRAC,
  parameter logic signed [WIDTH-1:0] COS_ROT      = 16'sh00B5,
  parameter logic signed [WIDTH-1:0] SIN_ROT      = 16'sh00B5,
  parameter logic signed [WIDTH-1:0] MOVE_STEP    = 16'sh0100,
  parameter int                      MAP_W        = 24,
  parameter int                      MAP_H        = 24,
  parameter int                      MAP_LAT      = 2,
  parameter int                      FRAME_LOCK   = 1,
  parameter logic signed [WIDTH-1:0] INIT_POS_X   = 16'sh0B80,
  parameter logic signed [WIDTH-1:0] INIT_POS_Y   = 16'sh0B80,
  parameter logic signed [WIDTH-1:0] INIT_DIR_X   = 16'sh0000,
  parameter logic signed [WIDTH-1:0] INIT_DIR_Y   = 16'shFF00,
  parameter logic signed [WIDTH-1:0] INIT_PLANE_X = 16'sh00A9,
  parameter logic signed [WIDTH-1:0] INIT_PLANE_Y = 16'sh0000,
  localparam int ADDR_W = $clog2(MAP_W * MAP_H)
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              cmd_valid_in,
  input  logic [2:0]        cmd_in,
  output logic              cmd_ready_out,
  input  logic              frame_sync_in,
  output logic              map_req_out,
  output logic [ADDR_W-1:0] map_addr_out,
  input  logic [3:0]        map_data_in,
  output logic [WIDTH-1:0]  posX,
  output logic [WIDTH-1:0]  posY,
  output logic [WIDTH-1:0]  dirX,
  output logic [WIDTH-1:0]  dirY,
  output logic [WIDTH-1:0]  planeX,
  output logic [WIDTH-1:0]  planeY,
  output logic              pose_update_out,
  output logic              collision_out
);

  localparam int IW    = WIDTH - FRAC;
  localparam int CNT_W = (MAP_LAT < 1) ? 1 : $clog2(MAP_LAT + 1);

  pose_state_t             state_reg;
  pose_cmd_t               cmd_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [WIDTH-1:0] cand_x_reg, cand_y_reg;
  logic signed [WIDTH-1:0] pos_x_reg, pos_y_reg, dir_x_reg, dir_y_reg;
  logic signed [WIDTH-1:0] plane_x_reg, plane_y_reg;
  logic                    ready_reg, map_req_reg, pose_update_reg, collision_reg;
  logic [ADDR_W-1:0]       map_addr_reg;

  logic signed [WIDTH-1:0] mul_a [4];
  logic signed [WIDTH-1:0] mul_b [4];
  logic signed [WIDTH-1:0] prod  [4];
  logic signed [WIDTH-1:0] rot_x, rot_y, calc_x_next, calc_y_next;
  logic [IW-1:0]           cell_x, cell_y;
  logic                    off_map, commit_go;
  logic [ADDR_W-1:0]       cell_addr;
  pose_cmd_t               cmd_in_t;

  assign cmd_in_t = pose_cmd_t'(cmd_in);

  // The rotator is shared: in CALC it rotates dir (result parked in cand_*),
  // in COMMIT it rotates plane, which is stable until the commit itself.
  // Translations borrow instances 0 and 1 for dir*MOVE_STEP.
  always_comb begin
    rot_x    = (state_reg == ST_COMMIT) ? plane_x_reg : dir_x_reg;
    rot_y    = (state_reg == ST_COMMIT) ? plane_y_reg : dir_y_reg;
    mul_a[0] = rot_x;  mul_b[0] = COS_ROT;
    mul_a[1] = rot_y;  mul_b[1] = SIN_ROT;
    mul_a[2] = rot_x;  mul_b[2] = SIN_ROT;
    mul_a[3] = rot_y;  mul_b[3] = COS_ROT;
    if (!is_rotate(cmd_reg)) begin
      mul_a[0] = dir_x_reg;  mul_b[0] = MOVE_STEP;
      mul_a[1] = dir_y_reg;  mul_b[1] = MOVE_STEP;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mul
    fxp_mul_shift #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
      .a_in (mul_a[gi]),
      .b_in (mul_b[gi]),
      .p_out(prod[gi])
    );
  end

  // Strafe right moves along (-dirY, dirX); strafe left is its negation.
  always_comb begin
    calc_x_next = pos_x_reg;
    calc_y_next = pos_y_reg;
    case (cmd_reg)
      CMD_FWD:   begin calc_x_next = pos_x_reg + prod[0]; calc_y_next = pos_y_reg + prod[1]; end
      CMD_BWD:   begin calc_x_next = pos_x_reg - prod[0]; calc_y_next = pos_y_reg - prod[1]; end
      CMD_STR_R: begin calc_x_next = pos_x_reg - prod[1]; calc_y_next = pos_y_reg + prod[0]; end
      CMD_STR_L: begin calc_x_next = pos_x_reg + prod[1]; calc_y_next = pos_y_reg - prod[0]; end
      CMD_ROT_L: begin calc_x_next = prod[0] - prod[1];   calc_y_next = prod[2] + prod[3];   end
      CMD_ROT_R: begin calc_x_next = prod[0] + prod[1];   calc_y_next = prod[3] - prod[2];   end
      default:   ;
    endcase
  end

  // Bounds are decided on the candidate as it leaves CALC, so an off-map
  // move never issues a map read.
  assign cell_x    = calc_x_next[WIDTH-1:FRAC];
  assign cell_y    = calc_y_next[WIDTH-1:FRAC];
  assign off_map   = calc_x_next[WIDTH-1] | calc_y_next[WIDTH-1] |
                     (int'(cell_x) >= MAP_W) | (int'(cell_y) >= MAP_H);
  assign cell_addr = ADDR_W'(int'(cell_y) * MAP_W + int'(cell_x));
  assign commit_go = (FRAME_LOCK == 0) || frame_sync_in;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg       <= ST_IDLE;
      cmd_reg         <= CMD_NOP;
      cnt_reg         <= '0;
      cand_x_reg      <= '0;
      cand_y_reg      <= '0;
      pos_x_reg       <= INIT_POS_X;
      pos_y_reg       <= INIT_POS_Y;
      dir_x_reg       <= INIT_DIR_X;
      dir_y_reg       <= INIT_DIR_Y;
      plane_x_reg     <= INIT_PLANE_X;
      plane_y_reg     <= INIT_PLANE_Y;
      ready_reg       <= 1'b1;
      map_req_reg     <= 1'b0;
      map_addr_reg    <= '0;
      pose_update_reg <= 1'b0;
      collision_reg   <= 1'b0;
    end else begin
      map_req_reg     <= 1'b0;
      pose_update_reg <= 1'b0;
      collision_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // NOP completes the handshake but leaves the FSM in IDLE.
          if (cmd_valid_in && ready_reg && (cmd_in_t != CMD_NOP)) begin
            cmd_reg   <= cmd_in_t;
            ready_reg <= 1'b0;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          cand_x_reg <= calc_x_next;
          cand_y_reg <= calc_y_next;
          if (is_rotate(cmd_reg)) begin
            state_reg <= ST_COMMIT;
          end else if (off_map) begin
            collision_reg <= 1'b1;
            state_reg     <= ST_REJECT;
          end else begin
            map_req_reg  <= 1'b1;
            map_addr_reg <= cell_addr;
            cnt_reg      <= '0;
            state_reg    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // The request cycle plus MAP_LAT counted cycles lands exactly on
          // the cycle in which map_data_in is valid.
          if (cnt_reg == CNT_W'(MAP_LAT)) begin
            if (map_data_in != 4'd0) begin
              collision_reg <= 1'b1;
              state_reg     <= ST_REJECT;
            end else begin
              state_reg <= ST_COMMIT;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          if (commit_go) begin
            if (is_rotate(cmd_reg)) begin
              dir_x_reg   <= cand_x_reg;
              dir_y_reg   <= cand_y_reg;
              plane_x_reg <= calc_x_next;
              plane_y_reg <= calc_y_next;
            end else begin
              pos_x_reg <= cand_x_reg;
              pos_y_reg <= cand_y_reg;
            end
            pose_update_reg <= 1'b1;
            ready_reg       <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end
        ST_REJECT: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_out   = ready_reg;
  assign map_req_out     = map_req_reg;
  assign map_addr_out    = map_addr_reg;
  assign posX            = pos_x_reg;
  assign posY            = pos_y_reg;
  assign dirX            = dir_x_reg;
  assign dirY            = dir_y_reg;
  assign planeX          = plane_x_reg;
  assign planeY          = plane_y_reg;
  assign pose_update_out = pose_update_reg;
  assign collision_out   = collision_reg;

endmodule
